// File: rtl/ysyx_24100029_ifu_if.sv
// Fetch-unit bundle: memory request/response, redirect and decode handoff.
// master = fetch unit side, slave = memory/pipeline side.
interface ysyx_24100029_ifu_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_fault;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_err,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output out_fault
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_err,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  out_fault
  );
endinterface

// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: one outstanding word fetch, REQ -> WAIT -> HOLD.
// Redirects win over every other event; killed responses are dropped.
module ysyx_24100029_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic clock,
  input logic reset,
  ysyx_24100029_ifu_if.master io
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_q;
  logic            fault_q;
  logic            kill;
  logic            aligned;

  assign aligned = (pc[1:0] == 2'b00);

  assign io.mem_req_valid = (state == S_REQ)
                          & ~io.redirect_valid
                          & aligned
                          & ~reset;
  assign io.mem_req_addr  = pc;
  assign io.out_valid     = (state == S_HOLD)
                          & ~io.redirect_valid;
  assign io.out_pc        = pc;
  assign io.out_inst      = inst_q;
  assign io.out_fault     = fault_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= S_REQ;
      kill    <= 1'b0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (io.redirect_valid) begin
            pc <= io.redirect_pc;
          end else if (!aligned) begin
            inst_q  <= '0;
            fault_q <= 1'b1;
            state   <= S_HOLD;
          end else if (io.mem_req_ready) begin
            kill  <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response belonging to a redirected fetch is thrown away.
          if (io.mem_rsp_valid && (kill || io.redirect_valid)) begin
            if (io.redirect_valid) pc <= io.redirect_pc;
            kill  <= 1'b0;
            state <= S_REQ;
          end else if (io.redirect_valid) begin
            pc   <= io.redirect_pc;
            kill <= 1'b1;
          end else if (io.mem_rsp_valid) begin
            inst_q  <= io.mem_rsp_err ? '0 : io.mem_rsp_data;
            fault_q <= io.mem_rsp_err;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (io.redirect_valid) begin
            pc    <= io.redirect_pc;
            state <= S_REQ;
          end else if (io.out_ready) begin
            pc    <= pc + XLEN'(4);
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Randomized scoreboard bench: an architectural next-PC model predicts
// the delivered {pc, inst, fault} stream; a monitor checks each handoff.
module tb_ysyx_24100029_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst;

  ysyx_24100029_ifu_if #(.XLEN(32)) bus ();

  ysyx_24100029_ifu #(
    .XLEN    (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock(clk),
    .reset(rst),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_chk;
  int          n_pass;
  int          n_xfer;
  logic [31:0] model_pc;

  // responder state
  logic        pending;
  int          delay;
  logic [31:0] paddr;
  logic        rsp_block;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] w;
    if (a == RESET_PC) return 1'b0;
    w = mem_word(a);
    return (w[7:4] == 4'h0);
  endfunction

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.fault = (a[1:0] != 2'b00) || mem_err(a);
    e.inst  = e.fault ? 32'h0 : mem_word(a);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: compares DUT outputs against the scoreboard at negedge.
  logic        stall;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic        s_fault;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      stall = 1'b0;
    end else begin
      if (stall && !bus.redirect_valid) begin
        chk("hold_valid", 32'(bus.out_valid), 32'h1);
        chk("hold_pc", bus.out_pc, s_pc);
        chk("hold_inst", bus.out_inst, s_inst);
        chk("hold_fault", 32'(bus.out_fault), 32'(s_fault));
      end
      if (bus.mem_req_valid) begin
        chk("req_align", 32'(bus.mem_req_addr[1:0]), 32'h0);
        if (exp_q.size() == 0) fail_now("req_unexpected");
        else chk("req_addr", bus.mem_req_addr, exp_q[0].pc);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("xfer_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_inst", bus.out_inst, e.inst);
          chk("out_fault", 32'(bus.out_fault), 32'(e.fault));
        end
        n_xfer++;
      end
      stall   = bus.out_valid && !bus.out_ready;
      s_pc    = bus.out_pc;
      s_inst  = bus.out_inst;
      s_fault = bus.out_fault;
    end
  end

  // One clock of stimulus: model update for last handoff, then memory.
  task automatic tick();
    logic fire;
    logic xf;
    @(negedge clk);
    fire = bus.mem_req_valid && bus.mem_req_ready;
    xf   = bus.out_valid && bus.out_ready;
    @(posedge clk);
    #1;
    if (xf) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back(predict(model_pc));
    end
    bus.mem_rsp_valid = 1'b0;
    if (fire) begin
      pending = 1'b1;
      paddr   = bus.mem_req_addr;
      delay   = $urandom_range(0, 2);
    end
    if (pending && !rsp_block) begin
      if (delay == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_word(paddr);
        bus.mem_rsp_err   = mem_err(paddr);
        pending           = 1'b0;
      end else begin
        delay--;
      end
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    model_pc           = t;
    exp_q.delete();
    exp_q.push_back(predict(t));
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return RESET_PC + {24'h0, r[5:0], 2'b00};
      1: return 32'hFFFF_FFF4 + {28'h0, 2'(r[0]), 2'b00};
      2: return 32'h8000_0102;
      3: return {r[31:2], 2'b00};
      4: return RESET_PC + 32'h100;
      default: return r;
    endcase
  endfunction

  initial begin
    int last;
    int idle;
    int prog;
    n_chk  = 0;
    n_pass = 0;
    n_xfer = 0;
    stall  = 1'b0;
    pending   = 1'b0;
    delay     = 0;
    paddr     = 32'h0;
    rsp_block = 1'b0;
    model_pc  = RESET_PC;
    rst = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.mem_rsp_err    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.push_back(predict(RESET_PC));

    // Clean start: first instruction from the reset vector.
    repeat (8) tick();

    last = n_xfer;
    idle = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = 1'b0;
      if ($urandom_range(0, 15) == 0) redirect(pick_target());
      if (n_xfer != last) begin
        last = n_xfer;
        idle = 0;
      end else if (++idle > 300) begin
        fail_now("progress_timeout");
        idle = 0;
      end
    end
    chk("enough_xfers", 32'(n_xfer > 300), 32'h1);

    // Reset while a fetch is outstanding; the late response must be dropped.
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    bus.mem_req_ready  = 1'b1;
    rsp_block          = 1'b1;
    for (int i = 0; i < 60 && !pending; i++) tick();
    chk("wait_reached", 32'(pending), 32'h1);
    tick();
    rst = 1'b1;
    bus.mem_req_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    model_pc = RESET_PC;
    exp_q.push_back(predict(RESET_PC));
    rsp_block = 1'b0;
    repeat (5) tick();
    chk("late_rsp_gone", 32'(pending), 32'h0);
    prog = n_xfer;
    bus.mem_req_ready = 1'b1;
    repeat (10) tick();
    chk("post_reset_xfer", 32'(n_xfer > prog), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_ifu.md
Name: ysyx_24100029_ifu

Overview:
Instruction fetch unit of the NPC core. It holds the PC and issues one word-aligned fetch per instruction over a request/response memory port. It hands {pc, inst, fault} to the decode stage over a valid/ready handshake; decode feeds the opcode/funct fields into the MuxKey lookup tables. It accepts redirects (branch/jump/trap) from the execute/writeback stages.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction paths.

Ports:
- clock, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- mem_req_valid, output, 1, fetch request valid.
- mem_req_ready, input, 1, memory accepts request.
- mem_req_addr, output, XLEN, fetch address (equals pc).
- mem_rsp_valid, input, 1, response valid (one cycle per request).
- mem_rsp_data, input, XLEN, fetched instruction word.
- mem_rsp_err, input, 1, access fault on this response.
- redirect_valid, input, 1, load new PC.
- redirect_pc, input, XLEN, redirect target.
- out_valid, output, 1, instruction available to decode.
- out_ready, input, 1, decode accepts.
- out_pc, output, XLEN, PC of out_inst.
- out_inst, output, XLEN, instruction word (0 when out_fault).
- out_fault, output, 1, fetch fault: access error or misaligned PC.

Behaviour:
- Reset, while reset=1 at an edge:
  - pc<=RESET_PC, state<=REQ, kill<=0, inst_q<=0, fault_q<=0.
  - Outputs during reset: mem_req_valid=0, out_valid=0.
  - Reset mid-fetch: any later mem_rsp_valid for the old request is ignored while in REQ.
- States REQ, WAIT, HOLD. Registers: pc, inst_q, fault_q, kill.
- Combinational outputs:
  - mem_req_valid = (state==REQ) & !redirect_valid & (pc[1:0]==0) & !reset.
  - mem_req_addr = pc.
  - out_valid = (state==HOLD) & !redirect_valid.
  - out_pc = pc, out_inst = inst_q, out_fault = fault_q.
- REQ:
  - If redirect_valid: pc<=redirect_pc; stay in REQ.
  - Else if pc[1:0]!=0: inst_q<=0, fault_q<=1, go to HOLD with no memory request.
  - Else if mem_req_ready: go to WAIT, kill<=0.
  - Else stay in REQ, holding the request stable.
- WAIT:
  - redirect_valid (no response this cycle): pc<=redirect_pc, kill<=1; stay in WAIT.
  - mem_rsp_valid & (kill | redirect_valid): discard the response. If redirect_valid, also pc<=redirect_pc. kill<=0, go to REQ.
  - mem_rsp_valid otherwise: inst_q<=err?0:data, fault_q<=err, go to HOLD.
  - Minimum fetch latency, request accept to out_valid: 1 cycle after mem_rsp_valid.
- HOLD:
  - redirect_valid: pc<=redirect_pc, go to REQ. No transfer occurs even if out_ready=1.
  - Else if out_ready: pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to REQ.
  - Else hold all outputs stable.
  - After an accepted fault the PC still advances by 4; the trap handler redirects.
- Redirect priority over every other event. The unit has at most one outstanding request, so there is no response reordering.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD) with a zero-wait memory.
- mem_rsp_valid seen in REQ or HOLD is ignored, as a protocol violation.

Test Plan:
- Reset release, mem always ready, 1-cycle response, data 32'h00000013, out_ready=1 -> first request addr 32'h8000_0000; out_pc 8000_0000, out_inst 00000013; next request at 8000_0004.
- out_ready held 0 for 5 cycles in HOLD -> out_valid, out_pc and out_inst stable; no new mem_req_valid; pc advances only on the ready cycle.
- redirect_valid with redirect_pc=8000_0100 in WAIT, response 2 cycles later with data 32'hDEADBEEF -> response discarded, never out_valid; next request addr 8000_0100.
- redirect in HOLD concurrent with out_ready=1 -> out_valid=0 that cycle, no transfer; next request at the redirect target.
- mem_rsp_err=1 -> out_fault=1, out_inst=0; accepted transfer advances pc by 4. Redirect to 8000_0102 -> no mem request; out_fault=1, out_pc=8000_0102.
- pc=32'hFFFF_FFFC accepted -> next request addr 32'h0000_0000. Assert reset while in WAIT -> state REQ, pc=RESET_PC; late response ignored.
